update_port_arbiter: RTL and testbench
======================================

# update_port_arbiter

Round-robin arbiter that shares the single update (port B) write path of the AXI4-Lite register cache between several LSTM datapath requesters. Each cycle it grants at most one requester and drives a registered update_valid/update_addr/update_data beat toward the cache. The cache's port B is shared between these updates and host AXI reads, and updates take priority on that port. To keep host readback from starving, the arbiter therefore forces a one-cycle yield after a bounded burst of grants while a host read is pending.

## Interface
Parameters:
- N_REQ, 4: number of requesters, 2..16.
- ADDR_W, 32: update address width.
- DATA_W, 32: update data width.
- MAX_BURST, 4: maximum consecutive grants while read_pending is high before a forced idle cycle, ≥1.

Ports:
- clk  in  1  clock.
- rst  in  1  reset. Synchronous, active-high.
- req_valid  in  N_REQ  per-requester write request.
- req_addr  in  N_REQ*ADDR_W  packed addresses; requester i occupies bits [i*ADDR_W +: ADDR_W].
- req_data  in  N_REQ*DATA_W  packed data, same packing.
- req_ready  out  N_REQ  one-hot or zero; the beat of requester i is accepted when req_valid[i] && req_ready[i].
- read_pending  in  1  a host AXI read is waiting for port B.
- update_valid  out  1  registered write strobe to the cache update port.
- update_addr  out  ADDR_W  registered address.
- update_data  out  DATA_W  registered data.
- grant_id  out  max(1,$clog2(N_REQ))  index of the requester whose beat is on update_*.
- yield  out  1  high during a forced idle cycle.

## Operation
State machine with two states, ARB and YIELD. Reset state is ARB.

ARB:
- Search req_valid for the first valid requester starting at (last_grant+1) mod N_REQ, wrapping around.
- If one is found, assert that requester's req_ready in the same cycle (combinational from req_valid, state, and counters).
- On acceptance, set last_grant to the winner.
- If no requester is valid, req_ready = 0 and last_grant is unchanged.

Burst counter burst_cnt (0..MAX_BURST):
- If read_pending=0: clear to 0.
- Else, on each granted cycle: increment.
- When read_pending=1 and burst_cnt==MAX_BURST at the start of a cycle: grant nothing; transition to YIELD at the next edge.

YIELD (exactly one cycle):
- req_ready=0, yield=1, update_valid=0 on the following edge.
- burst_cnt cleared to 0.
- Returns to ARB unconditionally.

Other rules:
- Requesters that are not granted must hold their request stable; the arbiter has no per-requester buffering.
- Reset values: update_valid=0, update_addr=0, update_data=0, grant_id=0, yield=0, req_ready=0, burst_cnt=0, last_grant=N_REQ-1 (requester 0 wins first).
- rst asserted mid-burst drops any beat not yet registered; a beat registered on the reset edge is discarded (update_valid=0 after reset).

## Timing
- Request-to-update latency: 1 cycle. A beat accepted at edge k appears on update_* during cycle k+1 (valid for one cycle).
- Back-to-back grants are allowed every cycle; peak throughput is 1 beat/cycle.
- With read_pending held high and all requesters valid, the pattern is MAX_BURST grant cycles then 1 idle cycle, repeating.
- read_pending falling during a burst clears burst_cnt at the next edge; no yield occurs.
- read_pending rising when burst_cnt is already 0 starts counting from 0.
- yield is a registered output, high during the idle cycle itself.

## Test plan
- Single requester: after reset, req_valid=0001, addr 0x10, data 0xA5 → req_ready=0001 the same cycle; next cycle update_valid=1, update_addr=0x10, update_data=0xA5, grant_id=0.
- Round-robin fairness: all four valid continuously, read_pending=0 → grant_id sequence 0,1,2,3,0,1,… with no gaps across 12 cycles.
- Skip idle requesters: req_valid=1010 starting from last_grant=3 → grants 1,3,1,3.
- Read yield: all valid, read_pending=1, MAX_BURST=4 → 4 grants, then one cycle with update_valid=0 and yield=1, then grants resume in rotation order.
- read_pending drops after 2 grants → no yield; continuous grants with burst_cnt reset.
- Reset mid-stream: assert rst during a grant cycle → next cycle update_valid=0 and grant_id=0; first grant after release goes to requester 0.

Source files
------------

// File: rtl/update_port_arbiter.sv
// -----------------------------------------------------------------------------
// update_port_arbiter
//
// Round-robin arbiter sharing the register cache's update (port B) write path
// between several LSTM datapath requesters. At most one requester is granted
// per cycle; the granted beat is registered onto o_update_* one cycle later.
// While a host read is pending, a burst of MAX_BURST grants is followed by one
// forced idle cycle so host readback on port B cannot starve.
//
// The YIELD state is the cycle in which nothing is granted. Because update_*
// is registered, the port B slot it frees appears one cycle later. o_yield is
// registered from the state, so it is high in that same freed cycle, where
// o_update_valid is 0.
//
// Ports:
//   clk             clock
//   rst             synchronous active-high reset
//   i_req_valid     per-requester write request            [N_REQ]
//   i_req_addr      packed addresses, requester i at [i*ADDR_W +: ADDR_W]
//   i_req_data      packed data, requester i at [i*DATA_W +: DATA_W]
//   o_req_ready     one-hot or zero grant; beat accepted on valid && ready
//   i_read_pending  a host AXI read is waiting for port B
//   o_update_valid  registered write strobe to the cache update port
//   o_update_addr   registered update address
//   o_update_data   registered update data
//   o_grant_id      requester index of the beat on o_update_*
//   o_yield         registered; high in the port B cycle freed for the host
// -----------------------------------------------------------------------------
module update_port_arbiter #(
   parameter int N_REQ     = 4,
   parameter int ADDR_W    = 32,
   parameter int DATA_W    = 32,
   parameter int MAX_BURST = 4,
   localparam int GID_W    = (N_REQ > 2) ? $clog2(N_REQ) : 1,
   localparam int CNT_W    = (MAX_BURST > 1) ? $clog2(MAX_BURST + 1) : 1
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [N_REQ-1:0]        i_req_valid,
   input  logic [N_REQ*ADDR_W-1:0] i_req_addr,
   input  logic [N_REQ*DATA_W-1:0] i_req_data,
   output logic [N_REQ-1:0]        o_req_ready,
   input  logic                    i_read_pending,
   output logic                    o_update_valid,
   output logic [ADDR_W-1:0]       o_update_addr,
   output logic [DATA_W-1:0]       o_update_data,
   output logic [GID_W-1:0]        o_grant_id,
   output logic                    o_yield
);

   typedef enum logic [0:0] {
      ST_ARB   = 1'b0,
      ST_YIELD = 1'b1
   } state_t;

   state_t            r_state;
   logic [GID_W-1:0]  r_last_grant;
   logic [CNT_W-1:0]  r_burst_cnt;

   logic              w_burst_full;
   logic              w_found;
   logic [GID_W-1:0]  w_grant_idx;

   // (base + off) mod N_REQ for off in 1..N_REQ; one subtraction suffices.
   function automatic logic [GID_W-1:0] rr_index(input logic [GID_W-1:0] base,
                                                  input int off);
      int sum;
      sum = int'(base) + off;
      if (sum >= N_REQ) sum = sum - N_REQ;
      return GID_W'(sum);
   endfunction

   assign w_burst_full = i_read_pending && (r_burst_cnt == CNT_W'(MAX_BURST));

   // Search starts just after the last winner, so the most recent winner has
   // lowest priority on the next pick.
   always_comb begin
      // NOTE: every always_comb output gets a default first so no path leaves
      // it unassigned, which would otherwise infer a latch.
      w_found     = 1'b0;
      w_grant_idx = '0;
      if (r_state == ST_ARB && !w_burst_full) begin
         for (int off = 1; off <= N_REQ; off++) begin
            if (!w_found && i_req_valid[rr_index(r_last_grant, off)]) begin
               w_found     = 1'b1;
               w_grant_idx = rr_index(r_last_grant, off);
            end
         end
      end
   end

   always_comb begin
      o_req_ready = '0;
      if (w_found) o_req_ready[w_grant_idx] = 1'b1;
   end

   // NOTE: all state below is sequential and uses non-blocking assignments so
   // every register samples the pre-edge values of the others.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state        <= ST_ARB;
         r_last_grant   <= GID_W'(N_REQ - 1);
         r_burst_cnt    <= '0;
         o_update_valid <= 1'b0;
         o_update_addr  <= '0;
         o_update_data  <= '0;
         o_grant_id     <= '0;
         o_yield        <= 1'b0;
      end else begin
         // A ready grant to a valid requester is always an acceptance.
         o_update_valid <= w_found;
         if (w_found) begin
            o_update_addr <= i_req_addr[int'(w_grant_idx)*ADDR_W +: ADDR_W];
            o_update_data <= i_req_data[int'(w_grant_idx)*DATA_W +: DATA_W];
            o_grant_id    <= w_grant_idx;
            r_last_grant  <= w_grant_idx;
         end

         o_yield <= (r_state == ST_YIELD);

         case (r_state)
            ST_ARB: begin
               if (w_burst_full) begin
                  // Counter already full on entry: idle here and yield next.
                  r_state <= ST_YIELD;
               end else if (!i_read_pending) begin
                  r_burst_cnt <= '0;
               end else if (w_found) begin
                  r_burst_cnt <= r_burst_cnt + 1'b1;
                  // The MAX_BURST-th grant moves straight to YIELD, so the
                  // burst is followed by exactly one non-granting cycle.
                  if (r_burst_cnt == CNT_W'(MAX_BURST - 1)) r_state <= ST_YIELD;
               end
            end
            ST_YIELD: begin
               r_state     <= ST_ARB;
               r_burst_cnt <= '0;
            end
            default: r_state <= ST_ARB;
         endcase
      end
   end

endmodule

// File: tb/tb_update_port_arbiter.sv
module tb_update_port_arbiter;

   localparam int N_REQ     = 4;
   localparam int ADDR_W    = 32;
   localparam int DATA_W    = 32;
   localparam int MAX_BURST = 4;

   logic                    clk;
   logic                    rst;
   logic [N_REQ-1:0]        req_valid;
   logic [N_REQ*ADDR_W-1:0] req_addr;
   logic [N_REQ*DATA_W-1:0] req_data;
   logic [N_REQ-1:0]        req_ready;
   logic                    read_pending;
   logic                    update_valid;
   logic [ADDR_W-1:0]       update_addr;
   logic [DATA_W-1:0]       update_data;
   logic [1:0]              grant_id;
   logic                    yield_o;

   int checks   = 0;
   int failures = 0;

   update_port_arbiter #(
      .N_REQ(N_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_BURST(MAX_BURST)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .i_req_valid    (req_valid),
      .i_req_addr     (req_addr),
      .i_req_data     (req_data),
      .o_req_ready    (req_ready),
      .i_read_pending (read_pending),
      .o_update_valid (update_valid),
      .o_update_addr  (update_addr),
      .o_update_data  (update_data),
      .o_grant_id     (grant_id),
      .o_yield        (yield_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [ADDR_W-1:0] exp_addr(input int i);
      return 32'h0000_0100 + 32'(i * 4);
   endfunction

   function automatic logic [DATA_W-1:0] exp_data(input int i);
      return 32'hD000_0000 + 32'(i);
   endfunction

   // Advance to just after the next rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic load_payloads();
      for (int i = 0; i < N_REQ; i++) begin
         req_addr[i*ADDR_W +: ADDR_W] = exp_addr(i);
         req_data[i*DATA_W +: DATA_W] = exp_data(i);
      end
   endtask

   task automatic do_reset();
      rst          = 1'b1;
      req_valid    = '0;
      read_pending = 1'b0;
      load_payloads();
      tick();
      tick();
      rst = 1'b0;
   endtask

   // Check one cycle: grant seen before the edge, then the registered beat.
   task automatic cycle_check(input string name, input int c,
                              input logic [3:0] exp_ready, input logic exp_yield);
      int w;
      @(negedge clk);
      checks++;
      if (req_ready !== exp_ready) begin
         failures++;
         $display("FAIL %s c%0d req_ready got=%b exp=%b", name, c, req_ready, exp_ready);
      end
      tick();
      w = (exp_ready == 4'b0001) ? 0 : (exp_ready == 4'b0010) ? 1 :
          (exp_ready == 4'b0100) ? 2 : 3;
      checks++;
      if (update_valid !== (exp_ready != 4'b0000)) begin
         failures++;
         $display("FAIL %s c%0d update_valid got=%b exp=%b", name, c, update_valid,
                  exp_ready != 4'b0000);
      end
      if (exp_ready != 4'b0000) begin
         checks++;
         if (grant_id !== 2'(w) || update_addr !== exp_addr(w) || update_data !== exp_data(w)) begin
            failures++;
            $display("FAIL %s c%0d beat got id=%0d addr=%h data=%h exp id=%0d addr=%h data=%h",
                     name, c, grant_id, update_addr, update_data, w, exp_addr(w), exp_data(w));
         end
      end
      checks++;
      if (yield_o !== exp_yield) begin
         failures++;
         $display("FAIL %s c%0d yield got=%b exp=%b", name, c, yield_o, exp_yield);
      end
   endtask

   task automatic test_reset();
      do_reset();
      checks++;
      if (update_valid !== 1'b0 || update_addr !== '0 || update_data !== '0 ||
          grant_id !== 2'd0 || yield_o !== 1'b0 || req_ready !== 4'b0000) begin
         failures++;
         $display("FAIL reset_values got v=%b a=%h d=%h id=%0d y=%b rdy=%b exp all zero",
                  update_valid, update_addr, update_data, grant_id, yield_o, req_ready);
      end
   endtask

   task automatic test_single();
      do_reset();
      req_addr[ADDR_W-1:0] = 32'h10;
      req_data[DATA_W-1:0] = 32'hA5;
      req_valid = 4'b0001;
      @(negedge clk);
      checks++;
      if (req_ready !== 4'b0001) begin
         failures++;
         $display("FAIL single_ready got=%b exp=0001", req_ready);
      end
      tick();
      req_valid = 4'b0000;
      checks++;
      if (update_valid !== 1'b1 || update_addr !== 32'h10 || update_data !== 32'hA5 ||
          grant_id !== 2'd0) begin
         failures++;
         $display("FAIL single_beat got v=%b a=%h d=%h id=%0d exp v=1 a=10 d=a5 id=0",
                  update_valid, update_addr, update_data, grant_id);
      end
      tick();
      checks++;
      if (update_valid !== 1'b0) begin
         failures++;
         $display("FAIL single_one_shot update_valid got=%b exp=0", update_valid);
      end
      load_payloads();
   endtask

   task automatic test_round_robin();
      do_reset();
      req_valid = 4'b1111;
      for (int c = 0; c < 12; c++)
         cycle_check("round_robin", c, 4'b0001 << (c % 4), 1'b0);
   endtask

   task automatic test_skip_idle();
      logic [3:0] exp_seq [4] = '{4'b0010, 4'b1000, 4'b0010, 4'b1000};
      do_reset();
      req_valid = 4'b1010;
      for (int c = 0; c < 4; c++)
         cycle_check("skip_idle", c, exp_seq[c], 1'b0);
   endtask

   task automatic test_read_yield();
      logic [3:0] exp_seq [10] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0000,
                                   4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0000};
      do_reset();
      req_valid    = 4'b1111;
      read_pending = 1'b1;
      // Yield is visible in the cycle whose update beat is missing.
      for (int c = 0; c < 10; c++)
         cycle_check("read_yield", c, exp_seq[c], exp_seq[c] == 4'b0000);
   endtask

   task automatic test_pending_drop();
      logic [3:0] exp_seq [10] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001,
                                   4'b0010, 4'b0100, 4'b1000, 4'b0000, 4'b0001};
      logic       rp_seq  [10] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1,
                                   1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
      do_reset();
      req_valid = 4'b1111;
      // Two grants, drop read_pending, then a fresh full burst from zero.
      for (int c = 0; c < 10; c++) begin
         read_pending = rp_seq[c];
         cycle_check("pending_drop", c, exp_seq[c], exp_seq[c] == 4'b0000);
      end
   endtask

   task automatic test_reset_mid();
      do_reset();
      req_valid = 4'b1111;
      cycle_check("reset_mid_pre", 0, 4'b0001, 1'b0);
      cycle_check("reset_mid_pre", 1, 4'b0010, 1'b0);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      checks++;
      if (update_valid !== 1'b0 || grant_id !== 2'd0) begin
         failures++;
         $display("FAIL reset_mid_drop got v=%b id=%0d exp v=0 id=0", update_valid, grant_id);
      end
      cycle_check("reset_mid_post", 0, 4'b0001, 1'b0);
      cycle_check("reset_mid_post", 1, 4'b0010, 1'b0);
   endtask

   initial begin
      rst          = 1'b1;
      req_valid    = '0;
      req_addr     = '0;
      req_data     = '0;
      read_pending = 1'b0;
      test_reset();
      test_single();
      test_round_robin();
      test_skip_idle();
      test_read_yield();
      test_pending_drop();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
